// File: rtl/wbs_spi_master.sv
// wbs_spi_master
//   Wishbone slave that runs an external SPI bus as master. Byte-wide,
//   MSB-first transfers. Chip select is under software control, so
//   multi-byte frames are built from back-to-back TXDATA writes.
//
//   Register map (word index on wbs_adr_i):
//     0 CTRL   rw   [7:0] DIV, [8] CS, [9] CPOL, [10] CPHA
//     1 TXDATA w    [7:0] byte; starts a transfer when idle, else sets OVERRUN
//     2 RXDATA r    [7:0] last received byte; a read clears RX_VALID
//     3 STATUS r/w1c [0] BUSY, [1] RX_VALID, [2] OVERRUN
//   Any other address acks, reads 0 and ignores writes.
//
//   Optional build macro SPI_MODE_SEL_EN: when defined, CPOL/CPHA are
//   writable and all four SPI modes are supported. When undefined, only
//   mode 0 exists and CTRL[10:9] read 0.
//
// Ports:
//   clk, rst_n                    system clock, async active-low reset
//   wbs_stb_i, wbs_we_i           Wishbone strobe / write enable
//   wbs_adr_i[3:0], wbs_dat_i     register index / write data
//   wbs_dat_o, wbs_ack_o          read data (valid with ack) / acknowledge
//   spi_sck, spi_csn, spi_sdo     SPI clock, chip select (low), master out
//   spi_sdi                       SPI master in
module wbs_spi_master #(
  parameter logic [7:0] DIV_DEFAULT = 8'd11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        spi_sck,
  output logic        spi_csn,
  output logic        spi_sdo,
  input  logic        spi_sdi
);

  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;

  logic [7:0]  ctrl_div_q, lat_div_q, cnt_q, tx_q, rx_q, rxdata_q;
  logic [3:0]  edge_q;
  logic        cs_q, rxv_q, ovr_q;
  logic        ctrl_cpol, ctrl_cpha, lat_cpha;
  logic        busy, wr, rd, tx_wr, start, half_tc, done, leading;
  logic        do_sample, do_shift, sdo_next;
  logic        clr_rxv, clr_ovr, set_ovr;
  logic [7:0]  rx_next;
  logic [31:0] rdata;
  logic        unused_dat;

  // Side effects land on the edge that closes the ack cycle.
  assign wr      = wbs_stb_i && wbs_ack_o && wbs_we_i;
  assign rd      = wbs_stb_i && wbs_ack_o && !wbs_we_i;
  assign busy    = (state_q == SHIFT);
  assign tx_wr   = wr && (wbs_adr_i == 4'd1);
  assign start   = tx_wr && !busy;
  assign set_ovr = tx_wr && busy;
  assign clr_ovr = wr && (wbs_adr_i == 4'd3) && wbs_dat_i[2];
  assign clr_rxv = (wr && (wbs_adr_i == 4'd3) && wbs_dat_i[1]) ||
                   (rd && (wbs_adr_i == 4'd2));

  assign half_tc = busy && (cnt_q == lat_div_q);
  assign done    = half_tc && (edge_q == 4'd15);
  // Edge numbers are 1-based; an even count of completed edges means the
  // edge about to happen is odd, i.e. a leading edge.
  assign leading = !edge_q[0];
  assign rx_next = {rx_q[6:0], spi_sdi};
  assign unused_dat = ^wbs_dat_i;

`ifdef SPI_MODE_SEL_EN
  logic cpol_q, cpha_q, lat_cpha_q;
  assign ctrl_cpol = cpol_q;
  assign ctrl_cpha = cpha_q;
  assign lat_cpha  = lat_cpha_q;
  assign do_sample = half_tc && (lat_cpha ? !leading : leading);
  assign do_shift  = half_tc && (lat_cpha ? leading : !leading);
  // CPHA=0 already presented bit 7 at start, so the next bit is bit 6.
  assign sdo_next  = lat_cpha ? tx_q[7] : tx_q[6];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lat_cpha_q <= 1'b0;
    end else begin
      if (wr && (wbs_adr_i == 4'd0)) begin
        cpol_q <= wbs_dat_i[9];
        cpha_q <= wbs_dat_i[10];
      end
      if (start) lat_cpha_q <= cpha_q;
    end
  end
`else
  assign ctrl_cpol = 1'b0;
  assign ctrl_cpha = 1'b0;
  assign lat_cpha  = 1'b0;
  assign do_sample = half_tc && leading;
  assign do_shift  = half_tc && !leading;
  assign sdo_next  = tx_q[6];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (done)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata = '0;
    case (wbs_adr_i)
      4'd0:    rdata = {21'd0, ctrl_cpha, ctrl_cpol, cs_q, ctrl_div_q};
      4'd2:    rdata = {24'd0, rxdata_q};
      4'd3:    rdata = {29'd0, ovr_q, rxv_q, busy};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= '0;
      ctrl_div_q <= DIV_DEFAULT;
      cs_q       <= 1'b0;
      rxv_q      <= 1'b0;
      ovr_q      <= 1'b0;
      rxdata_q   <= '0;
      spi_csn    <= 1'b1;
    end else begin
      wbs_ack_o <= wbs_stb_i && !wbs_ack_o;
      wbs_dat_o <= (wbs_stb_i && !wbs_ack_o) ? rdata : '0;
      spi_csn   <= !cs_q;
      if (wr && (wbs_adr_i == 4'd0)) begin
        ctrl_div_q <= wbs_dat_i[7:0];
        cs_q       <= wbs_dat_i[8];
      end
      // Set wins over a simultaneous clear.
      if (done)         rxv_q <= 1'b1;
      else if (clr_rxv) rxv_q <= 1'b0;
      if (set_ovr)      ovr_q <= 1'b1;
      else if (clr_ovr) ovr_q <= 1'b0;
      if (done) rxdata_q <= do_sample ? rx_next : rx_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_div_q <= '0;
      cnt_q     <= '0;
      edge_q    <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      spi_sck   <= 1'b0;
      spi_sdo   <= 1'b0;
    end else if (!busy) begin
      spi_sck <= ctrl_cpol;
      if (start) begin
        lat_div_q <= ctrl_div_q;
        cnt_q     <= '0;
        edge_q    <= '0;
        tx_q      <= wbs_dat_i[7:0];
        rx_q      <= '0;
        if (!ctrl_cpha) spi_sdo <= wbs_dat_i[7];
      end
    end else begin
      cnt_q <= half_tc ? 8'd0 : cnt_q + 8'd1;
      if (half_tc) begin
        spi_sck <= !spi_sck;
        edge_q  <= edge_q + 4'd1;
      end
      if (do_sample) rx_q <= rx_next;
      if (do_shift) begin
        spi_sdo <= sdo_next;
        tx_q    <= {tx_q[6:0], 1'b0};
      end
    end
  end

endmodule
